// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl
// Iterative multiply/divide sequencer that produces the HI/LO values for the
// CPU's mult/div instructions without borrowing the main ALU.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start_mult, start_div : operation requests, sampled only while idle
//   op_a, op_b            : multiplicand/dividend and multiplier/divisor
//   hi, lo                : product halves, or remainder/quotient
//   busy                  : high while iterating or sign-fixing
//   done                  : one-cycle HI/LO write strobe
//   div_zero              : pulses together with done on a zero divisor
//
// Build option: define MULTDIV_UNSIGNED_EN to add the op_unsigned input,
// which selects unsigned multiply/divide.  Latencies do not depend on it.
module mult_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             op_unsigned,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] operand;      // multiplicand, or divisor magnitude
    // An extra guard bit on the upper half keeps the Booth subtract from
    // overflowing on -2^(WIDTH-1) operands, and holds the unsigned carry.
    logic [WIDTH:0]   acc_hi;       // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo;       // multiplier/product lower half / quotient
    logic             q_1;
    logic             neg_q;
    logic             neg_r;
    logic             is_uns;
    logic             div_zero_r;
    logic             unsigned_req;
    logic             last_iter;

`ifdef MULTDIV_UNSIGNED_EN
    assign unsigned_req = op_unsigned;
`else
    assign unsigned_req = 1'b0;
`endif

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state == MULT) || (state == DIV) || (state == FIX);
    assign done      = (state == DONE);
    assign div_zero  = div_zero_r;

    // Next-state logic; start_mult has priority over start_div.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_mult)
                    state_next = MULT;
                else if (start_div)
                    state_next = (op_b == '0) ? DONE : DIV;
            end
            MULT:    if (last_iter) state_next = DONE;
            DIV:     if (last_iter) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // One multiply step: Booth (or plain shift/add when unsigned) followed by
    // a right shift of the whole {acc_hi, acc_lo, q_1} accumulator.
    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   mult_hi_next;
    logic [WIDTH-1:0] mult_lo_next;
    logic             shift_in;

    always_comb begin
        mcand_ext = is_uns ? {1'b0, operand} : {operand[WIDTH-1], operand};
        booth_sum = acc_hi;
        if (is_uns) begin
            if (acc_lo[0]) booth_sum = acc_hi + mcand_ext;
        end else begin
            case ({acc_lo[0], q_1})
                2'b01:   booth_sum = acc_hi + mcand_ext;
                2'b10:   booth_sum = acc_hi - mcand_ext;
                default: booth_sum = acc_hi;
            endcase
        end
        shift_in     = is_uns ? 1'b0 : booth_sum[WIDTH];
        mult_hi_next = {shift_in, booth_sum[WIDTH:1]};
        mult_lo_next = {booth_sum[0], acc_lo[WIDTH-1:1]};
    end

    // One restoring-divide step.  The trial difference needs two extra bits:
    // the shifted remainder can reach nearly twice the divisor.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   div_hi_next;
    logic [WIDTH-1:0] div_lo_next;

    always_comb begin
        rem_sh      = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        trial       = {1'b0, rem_sh} - {2'b00, operand};
        div_hi_next = trial[WIDTH+1] ? rem_sh : trial[WIDTH:0];
        div_lo_next = {acc_lo[WIDTH-2:0], ~trial[WIDTH+1]};
    end

    // Operand magnitudes for signed divide.
    logic [WIDTH-1:0] a_mag, b_mag;
    always_comb begin
        a_mag = (!unsigned_req && op_a[WIDTH-1]) ? -op_a : op_a;
        b_mag = (!unsigned_req && op_b[WIDTH-1]) ? -op_b : op_b;
    end

    // Datapath registers.  hi/lo are loaded on the transition into DONE so
    // they are already valid while done is high, then hold until the next
    // completed operation.  A zero divisor leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            operand    <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            q_1        <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            is_uns     <= 1'b0;
            div_zero_r <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            div_zero_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        cnt     <= '0;
                        is_uns  <= unsigned_req;
                        operand <= op_a;
                        acc_hi  <= '0;
                        acc_lo  <= op_b;
                        q_1     <= 1'b0;
                    end else if (start_div) begin
                        cnt    <= '0;
                        is_uns <= unsigned_req;
                        if (op_b == '0) begin
                            div_zero_r <= 1'b1;
                        end else begin
                            operand <= b_mag;
                            acc_hi  <= '0;
                            acc_lo  <= a_mag;
                            neg_q   <= !unsigned_req && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                            neg_r   <= !unsigned_req && op_a[WIDTH-1];
                        end
                    end
                end
                MULT: begin
                    cnt    <= cnt + 1'b1;
                    acc_hi <= mult_hi_next;
                    acc_lo <= mult_lo_next;
                    q_1    <= acc_lo[0];
                    if (last_iter) begin
                        hi <= mult_hi_next[WIDTH-1:0];
                        lo <= mult_lo_next;
                    end
                end
                DIV: begin
                    cnt    <= cnt + 1'b1;
                    acc_hi <= div_hi_next;
                    acc_lo <= div_lo_next;
                end
                FIX: begin
                    // Remainder sign follows the dividend; -2^31/-1 wraps
                    // naturally because the quotient magnitude is 2^31.
                    lo <= neg_q ? -acc_lo : acc_lo;
                    hi <= neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
module tb_mult_div_ctrl;

    logic        clk;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    mult_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
`ifdef MULTDIV_UNSIGNED_EN
        .op_unsigned(1'b0),
`endif
        .op_a       (op_a),
        .op_b       (op_b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a request at the current negedge and pushes the reference result.
    task automatic issue(input bit do_mult, input bit do_div,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb_v, p, q, r;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        if (do_mult) begin
            p    = sa * sb_v;
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
        end else if (b == 32'd0) begin
            e.hi = model_hi;
            e.lo = model_lo;
            e.dz = 1'b1;
        end else begin
            q    = sa / sb_v;
            r    = sa % sb_v;
            e.hi = r[31:0];
            e.lo = q[31:0];
            e.dz = 1'b0;
        end
        model_hi = e.hi;
        model_lo = e.lo;
        sb.push_back(e);
        start_mult = do_mult;
        start_div  = do_div;
        op_a       = a;
        op_b       = b;
    endtask

    // Steps negedge by negedge until done, counting cycles and busy cycles.
    // Operands are scrambled after the start so latching is exercised.
    task automatic wait_done(input int pulse_at, output int cyc,
                             output int busy_cyc, output bit seen);
        cyc = 0; busy_cyc = 0; seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start_mult = 1'b0;
            start_div  = (cyc == pulse_at);
            op_a       = $urandom;
            op_b       = $urandom;
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        start_div = 1'b0;
    endtask

    // Pops the expected result and compares it with what the DUT presents.
    task automatic check_result(input string name, input int cyc, input int exp_cyc,
                                input int busy_cyc, input int exp_busy, input bit seen);
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (!seen || cyc != exp_cyc) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d (seen=%0d) expected %0d", name, cyc, seen, exp_cyc);
        end
        checks++;
        if (busy_cyc != exp_busy) begin
            errors++;
            $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", name, busy_cyc, exp_busy);
        end
        checks++;
        if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
            errors++;
            $display("[TB] FAIL %s result: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                     name, hi, lo, div_zero, e.hi, e.lo, e.dz);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b expected all zero",
                     hi, lo, busy, done, div_zero);
        end
        reset = 1'b0;
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int c, bc; bit s;
        issue(1, 0, 32'd7, 32'hFFFFFFFD);
        wait_done(0, c, bc, s);
        check_result("mult_7x-3", c, 33, bc, 32, s);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_pulse_width: got done=%b expected 0", done);
        end
        issue(1, 0, 32'h80000000, 32'h80000000);
        wait_done(0, c, bc, s);
        check_result("mult_min_sq", c, 33, bc, 32, s);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issue(1, 0, $urandom, $urandom);
            wait_done(0, c, bc, s);
            check_result("mult_rand", c, 33, bc, 32, s);
        end
        @(negedge clk);
    endtask

    task automatic test_div();
        int c, bc; bit s;
        logic [31:0] b;
        issue(0, 1, 32'hFFFFFFF9, 32'd2);
        wait_done(0, c, bc, s);
        check_result("div_-7/2", c, 34, bc, 33, s);
        @(negedge clk);
        issue(0, 1, 32'h80000000, 32'hFFFFFFFF);
        wait_done(0, c, bc, s);
        check_result("div_overflow", c, 34, bc, 33, s);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b = $urandom;
            if (i == 1) b = b >> 20;
            if (b == 32'd0) b = 32'd3;
            issue(0, 1, $urandom, b);
            wait_done(0, c, bc, s);
            check_result("div_rand", c, 34, bc, 33, s);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int c, bc; bit s;
        issue(1, 0, 32'h12345678, 32'h00000100);
        wait_done(0, c, bc, s);
        check_result("preload_mult", c, 33, bc, 32, s);
        @(negedge clk);
        issue(0, 1, 32'h55, 32'd0);
        wait_done(0, c, bc, s);
        check_result("div_zero", c, 1, bc, 0, s);
        @(negedge clk);
        checks++;
        if (div_zero !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL div_zero_pulse: got dz=%b done=%b expected 0 0", div_zero, done);
        end
    endtask

    task automatic test_ignored_starts();
        int c, bc, extra; bit s;
        issue(1, 1, 32'd9, 32'd4);
        wait_done(5, c, bc, s);
        check_result("both_starts", c, 33, bc, 32, s);
        // A start presented during DONE must also be dropped.
        start_div = 1'b1;
        op_b      = 32'd5;
        extra     = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start_div = 1'b0;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("[TB] FAIL ignored_start: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int c, bc; bit s;
        exp_t discard;
        issue(1, 0, 32'h1234, 32'h5678);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start_mult = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        discard = sb.pop_front();
        model_hi = '0;
        model_lo = '0;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_abort: got hi=%h lo=%h busy=%b done=%b expected 0 0 0 0",
                     hi, lo, busy, done);
        end
        c = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) c++;
        end
        checks++;
        if (c != 0) begin
            errors++;
            $display("[TB] FAIL reset_no_done: got %0d done cycles expected 0", c);
        end
        issue(1, 0, 32'd5, 32'd6);
        wait_done(0, c, bc, s);
        check_result("mult_after_reset", c, 33, bc, 32, s);
    endtask

    task automatic test_back_to_back();
        int c, bc; bit s;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                issue(1, 0, $urandom, $urandom);
                wait_done(0, c, bc, s);
                check_result("b2b_mult", c, 33, bc, 32, s);
            end else begin
                issue(0, 1, $urandom, $urandom_range(1, 1000));
                wait_done(0, c, bc, s);
                check_result("b2b_div", c, 34, bc, 33, s);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        model_hi   = '0;
        model_lo   = '0;
        $display("[TB] mult_div_ctrl bench start");
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_ignored_starts();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
